// File: rtl/embnew16k_nios2_qsys_0_jtag_debug_host.sv
// Host-side virtual-JTAG scan engine: plays UIR, CDR, SDR x SR_WIDTH, UDR on a
// generated TCK for one {IR, DR} command and returns the bits captured from TDO.
module embnew16k_nios2_qsys_0_jtag_debug_host #(
  parameter int unsigned SR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = $clog2(SR_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [SR_WIDTH-1:0] tx_q;
  logic [SR_WIDTH-1:0] rx_q;
  logic [SR_WIDTH-1:0] rsp_data_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic                tck_q;
  logic                tdi_q;
  logic                uir_q;
  logic                cdr_q;
  logic                sdr_q;
  logic                udr_q;
  logic                rti_q;
  logic                ready_q;
  logic                busy_q;
  logic                rsp_valid_q;

  logic                scan_c;
  logic                tc_c;
  logic                tck_rise_c;
  logic                tck_fall_c;
  logic [SR_WIDTH-1:0] tx_shift_c;

  // TCK advances only while a scan state is active; RESP and IDLE hold it low.
  assign scan_c     = (state_q == S_UIR) || (state_q == S_CDR) ||
                      (state_q == S_SDR) || (state_q == S_UDR);
  assign tc_c       = scan_c && (cnt_q == CNT_LAST);
  assign tck_rise_c = tc_c && !tck_q;
  assign tck_fall_c = tc_c && tck_q;
  assign tx_shift_c = tx_q >> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      ir_q        <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (scan_c) begin
        cnt_q <= tc_c ? '0 : cnt_q + CNT_W'(1);
      end
      if (tc_c) begin
        tck_q <= ~tck_q;
      end

      // Every state/strobe/TDI change lands on the edge that drives TCK low.
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            ir_q    <= cmd_ir;
            tx_q    <= cmd_data;
            rx_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            rti_q   <= 1'b0;
            uir_q   <= 1'b1;
            state_q <= S_UIR;
          end
        end
        S_UIR: begin
          if (tck_fall_c) begin
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
            state_q <= S_CDR;
          end
        end
        S_CDR: begin
          if (tck_fall_c) begin
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            tdi_q   <= tx_q[0];
            bit_q   <= '0;
            state_q <= S_SDR;
          end
        end
        S_SDR: begin
          if (tck_rise_c) begin
            rx_q <= {vji_tdo, rx_q[SR_WIDTH-1:1]};
          end
          if (tck_fall_c) begin
            if (bit_q == BIT_LAST) begin
              sdr_q   <= 1'b0;
              tdi_q   <= 1'b0;
              udr_q   <= 1'b1;
              state_q <= S_UDR;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              tx_q  <= tx_shift_c;
              tdi_q <= tx_shift_c[0];
            end
          end
        end
        S_UDR: begin
          if (tck_fall_c) begin
            udr_q   <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_q;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rti_q       <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_embnew16k_nios2_qsys_0_jtag_debug_host.sv
// Bench for the virtual-JTAG host: dut0 runs TCK_DIV=2, dut1 TCK_DIV=1, each
// driving a behavioural debug-module slave whose SR preloads on CDR.
module tb_embnew16k_nios2_qsys_0_jtag_debug_host;

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] data;
    logic [37:0] pre;
    logic [37:0] rsp;
    logic [37:0] sr;
  } vec_t;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] rsp;
    logic [37:0] sr;
  } exp_t;

  localparam logic [49:0] RST_SNAP = {2'b11, 48'd0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic        cmd_ready0, cmd_ready1;
  logic [1:0]  cmd_ir0 = '0, cmd_ir1 = '0;
  logic [37:0] cmd_data0 = '0, cmd_data1 = '0;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0 = 1'b1, rsp_ready1 = 1'b1;
  logic [37:0] rsp_data0, rsp_data1;
  logic        tck0, tck1, tdi0, tdi1, tdo0, tdo1;
  logic [1:0]  ir_in0, ir_in1;
  logic        uir0, cdr0, sdr0, udr0, rti0, busy0;
  logic        uir1, cdr1, sdr1, udr1, rti1, busy1;

  embnew16k_nios2_qsys_0_jtag_debug_host #(.TCK_DIV(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_ir(cmd_ir0), .cmd_data(cmd_data0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_data(rsp_data0), .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
    .vji_ir_in(ir_in0), .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0),
    .vji_rti(rti0), .busy(busy0)
  );

  embnew16k_nios2_qsys_0_jtag_debug_host #(.TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_ir(cmd_ir1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
    .vji_ir_in(ir_in1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1),
    .vji_rti(rti1), .busy(busy1)
  );

  // Behavioural debug-module slaves: capture preload on CDR, shift LSB-first on SDR.
  logic [37:0] pre0 = '0, pre1 = '0, sr0 = '0, sr1 = '0, sr_udr0 = '0, sr_udr1 = '0;
  int rises0 = 0, rises1 = 0;
  assign tdo0 = sr0[0];
  assign tdo1 = sr1[0];

  always @(posedge tck0) begin
    if (cdr0) sr0 <= pre0;
    else if (sdr0) begin
      sr0    <= {tdi0, sr0[37:1]};
      rises0 <= rises0 + 1;
    end
    if (udr0) sr_udr0 <= sr0;
  end

  always @(posedge tck1) begin
    if (cdr1) sr1 <= pre1;
    else if (sdr1) begin
      sr1    <= {tdi1, sr1[37:1]};
      rises1 <= rises1 + 1;
    end
    if (udr1) sr_udr1 <= sr1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_n [2] = '{0, 0};
  int acc_edge [2] = '{0, 0};
  int hs_n [2] = '{0, 0};
  int hs_edge [2] = '{0, 0};
  int hs_lat [2] = '{0, 0};
  int hs_uir [2] = '{0, 0};
  int hs_rises [2] = '{0, 0};
  int rv_rise_n [2] = '{0, 0};
  int rv_edge [2] = '{0, 0};
  int uir_n [2] = '{0, 0};
  int rise_base [2] = '{0, 0};
  int ord_bad [2] = '{0, 0};
  int ir_bad [2] = '{0, 0};
  logic [37:0] hs_data [2];
  logic [1:0]  hs_ir [2];
  logic        prv_rn [2] = '{1'b0, 1'b0};
  logic        prv_tck [2] = '{1'b0, 1'b0};
  logic        prv_rv [2] = '{1'b0, 1'b0};
  logic [4:0]  prv_sig [2] = '{5'd0, 5'd0};
  logic [1:0]  prv_ir [2] = '{2'd0, 2'd0};

  exp_t sb0 [$];
  exp_t sb1 [$];
  vec_t vecs [4];

  // Sees pre-edge values: what the previous edge produced.
  task automatic mon(input int id, input logic rn, input logic v, input logic rdy,
                     input logic [1:0] ir, input logic rv, input logic rr,
                     input logic [37:0] rd, input logic tck, input logic [4:0] sig,
                     input int rises);
    if (rn && prv_rn[id]) begin
      if (tck && !prv_tck[id] && (sig != prv_sig[id])) ord_bad[id]++;
      if (!sig[1] && sig[4]) ord_bad[id]++;
      if ((ir != prv_ir[id]) && (cyc - 1 != acc_edge[id])) ir_bad[id]++;
    end
    if (rv && !prv_rv[id]) begin
      rv_rise_n[id]++;
      rv_edge[id] = cyc - 1;
    end
    if (sig[3]) uir_n[id]++;
    if (rn && rv && rr) begin
      hs_n[id]++;
      hs_edge[id]  = cyc;
      hs_data[id]  = rd;
      hs_ir[id]    = ir;
      hs_lat[id]   = rv_edge[id] - acc_edge[id];
      hs_uir[id]   = uir_n[id];
      hs_rises[id] = rises - rise_base[id];
    end
    if (rn && v && rdy) begin
      acc_n[id]++;
      acc_edge[id]  = cyc;
      uir_n[id]     = 0;
      rise_base[id] = rises;
    end
    prv_rn[id]  = rn;
    prv_tck[id] = tck;
    prv_rv[id]  = rv;
    prv_sig[id] = sig;
    prv_ir[id]  = ir;
  endtask

  always @(posedge clk) begin
    cyc++;
    mon(0, reset_n, cmd_valid0, cmd_ready0, ir_in0, rsp_valid0, rsp_ready0, rsp_data0,
        tck0, {tdi0, uir0, cdr0, sdr0, udr0}, rises0);
    mon(1, reset_n, cmd_valid1, cmd_ready1, ir_in1, rsp_valid1, rsp_ready1, rsp_data1,
        tck1, {tdi1, uir1, cdr1, sdr1, udr1}, rises1);
  end

  function automatic void check(input int id, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %0h expected %0h (cycle %0d)", id, name, act, exp, cyc);
    end
  endfunction

  function automatic logic [49:0] snap(input int id);
    if (id == 0)
      return {cmd_ready0, rti0, tck0, tdi0, ir_in0, uir0, cdr0, sdr0, udr0, rsp_valid0, busy0, rsp_data0};
    return {cmd_ready1, rti1, tck1, tdi1, ir_in1, uir1, cdr1, sdr1, udr1, rsp_valid1, busy1, rsp_data1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int id, input int base);
    for (int i = 0; i < 20 && acc_n[id] == base; i++) tick();
    if (acc_n[id] == base) check(id, "accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive_cmd(input int id, input vec_t v);
    exp_t e;
    e = '{ir: v.ir, rsp: v.rsp, sr: v.sr};
    if (id == 0) begin
      pre0 = v.pre; cmd_ir0 = v.ir; cmd_data0 = v.data; cmd_valid0 = 1'b1;
      sb0.push_back(e);
    end else begin
      pre1 = v.pre; cmd_ir1 = v.ir; cmd_data1 = v.data; cmd_valid1 = 1'b1;
      sb1.push_back(e);
    end
  endtask

  task automatic issue(input int id, input vec_t v);
    int base;
    base = acc_n[id];
    drive_cmd(id, v);
    wait_acc(id, base);
    if (id == 0) cmd_valid0 = 1'b0; else cmd_valid1 = 1'b0;
  endtask

  task automatic finish_scan(input int id);
    int base;
    exp_t e;
    logic [37:0] sr_u;
    logic [2:0] idle;
    base = hs_n[id];
    for (int i = 0; i < 600 && hs_n[id] == base; i++) tick();
    if (hs_n[id] == base) begin
      check(id, "rsp_timeout", 64'd0, 64'd1);
    end else if (((id == 0) ? sb0.size() : sb1.size()) == 0) begin
      check(id, "scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e    = (id == 0) ? sb0.pop_front() : sb1.pop_front();
      sr_u = (id == 0) ? sr_udr0 : sr_udr1;
      idle = (id == 0) ? {cmd_ready0, busy0, rti0} : {cmd_ready1, busy1, rti1};
      check(id, "rsp_data", 64'(hs_data[id]), 64'(e.rsp));
      check(id, "ir_in", 64'(hs_ir[id]), 64'(e.ir));
      check(id, "slave_sr_at_udr", 64'(sr_u), 64'(e.sr));
      check(id, "rsp_latency", 64'(hs_lat[id]), (id == 0) ? 64'd165 : 64'd83);
      check(id, "uir_clk_cycles", 64'(hs_uir[id]), (id == 0) ? 64'd4 : 64'd2);
      check(id, "sdr_tck_rises", 64'(hs_rises[id]), 64'd38);
      check(id, "idle_after_hs", 64'(idle), 64'b101);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int base;
    vecs[0] = '{2'b01, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 38'h15_A5A5_A5A5};
    vecs[1] = '{2'b10, 38'h3F_FFFF_FFFF, 38'h00_0000_0000, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
    vecs[2] = '{2'b11, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
    vecs[3] = '{2'b00, 38'h00_0000_0001, 38'h20_0000_0000, 38'h20_0000_0000, 38'h00_0000_0001};

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check(0, "reset_state", 64'(snap(0)), 64'(RST_SNAP));
    check(1, "reset_state", 64'(snap(1)), 64'(RST_SNAP));

    for (int i = 0; i < 4; i++) begin
      issue(0, vecs[i]);
      finish_scan(0);
    end

    // Response backpressure: everything must freeze until rsp_ready.
    rsp_ready0 = 1'b0;
    base = rv_rise_n[0];
    issue(0, vecs[0]);
    for (int i = 0; i < 300 && rv_rise_n[0] == base; i++) tick();
    if (rv_rise_n[0] == base) check(0, "rsp_valid_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check(0, "backpressure_hold", 64'({rsp_valid0, tck0, cmd_ready0, busy0, rsp_data0}),
            64'({1'b1, 1'b0, 1'b0, 1'b1, vecs[0].rsp}));
    end
    rsp_ready0 = 1'b1;
    finish_scan(0);

    // Back-to-back with cmd_valid held: second accept one cycle after handshake.
    v = '{2'b10, 38'h2B_CDEF_0123, vecs[0].pre, vecs[0].rsp, 38'h2B_CDEF_0123};
    base = acc_n[0];
    drive_cmd(0, vecs[0]);
    wait_acc(0, base);
    base = acc_n[0];
    drive_cmd(0, v);
    finish_scan(0);
    check(0, "ir_before_2nd_accept", 64'(ir_in0), 64'(2'b01));
    wait_acc(0, base);
    cmd_valid0 = 1'b0;
    check(0, "b2b_accept_gap", 64'(acc_edge[0] - hs_edge[0]), 64'd1);
    check(0, "ir_after_2nd_accept", 64'(ir_in0), 64'(2'b10));
    finish_scan(0);

    // Reset pulse at the 10th SDR rising TCK.
    issue(0, vecs[1]);
    for (int i = 0; i < 300 && (rises0 - rise_base[0]) < 10; i++) tick();
    check(0, "rises_before_reset", 64'(rises0 - rise_base[0]), 64'd10);
    reset_n = 1'b0;
    #1;
    check(0, "async_reset_state", 64'(snap(0)), 64'(RST_SNAP));
    sb0.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    base = rv_rise_n[0];
    repeat (200) tick();
    check(0, "no_rsp_after_reset", 64'(rv_rise_n[0]), 64'(base));
    issue(0, vecs[0]);
    finish_scan(0);

    // TCK_DIV = 1 instance.
    issue(1, vecs[0]);
    finish_scan(1);
    issue(1, vecs[3]);
    finish_scan(1);

    check(0, "ordering_violations", 64'(ord_bad[0]), 64'd0);
    check(1, "ordering_violations", 64'(ord_bad[1]), 64'd0);
    check(0, "ir_change_outside_accept", 64'(ir_bad[0]), 64'd0);
    check(1, "ir_change_outside_accept", 64'(ir_bad[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/embnew16k_nios2_qsys_0_jtag_debug_host.md
# embnew16k_nios2_qsys_0_jtag_debug_host

Host-side virtual-JTAG scan engine: the initiator that drives the Nios II JTAG debug module's virtual-JTAG slave port (`vji_*`) from a system-clock command interface. It accepts one {IR, 38-bit DR} command at a time and plays the full UIR → CDR → SDR×38 → UDR sequence on a generated TCK. It returns the 38 bits shifted out of the debug module. It is used as an on-chip debug initiator and as the simulation driver for the debug-module wrapper in place of the sld_virtual_jtag_basic hard block.

## Interface
- `SR_WIDTH`, 38: DR scan length in TCK periods; must match the debug module shift register.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_DIV`, 2: TCK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  sole clock; every flop is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle, command accepted when `cmd_valid & cmd_ready`.
- `cmd_ir`  in  IR_WIDTH  virtual IR for this scan (0..3).
- `cmd_data`  in  SR_WIDTH  DR data to shift in, LSB first.
- `rsp_valid`  out  1  response held valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`  out  SR_WIDTH  bits captured from `vji_tdo`; first captured bit lands in bit 0.
- `vji_tck`  out  1  generated TCK (registered, glitch-free).
- `vji_tdi`  out  1  serial data to debug module.
- `vji_tdo`  in  1  serial data from debug module.
- `vji_ir_in`  out  IR_WIDTH  virtual IR value.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`  out  1 each  virtual state strobes.
- `vji_rti`  out  1  run-test-idle indication.
- `busy`  out  1  scan or response pending (state ≠ IDLE).

## Operation
- FSM states: IDLE, UIR, CDR, SDR, UDR, RESP.
- IDLE: `cmd_ready`=1, `vji_rti`=1, TCK held low, `vji_tdi`=0, all strobes 0. On accept:
  - latch `cmd_ir` into `vji_ir_in`;
  - load `cmd_data` into the TX shift register;
  - clear the RX register;
  - go to UIR.
- UIR, CDR, UDR each last exactly one TCK period; the matching strobe is high for that whole period.
- SDR lasts SR_WIDTH TCK periods with `vji_sdr`=1. `vji_tdi` = TX[0].
  - On each TCK rising edge: RX ← {`vji_tdo`, RX[SR_WIDTH-1:1]}.
  - On each TCK falling edge: TX ← TX >> 1.
- State, strobes, and `vji_tdi` change only at the `clk` edge that drives TCK low (falling TCK). The slave therefore always sees stable inputs at rising TCK.
- After the UDR period, go to RESP:
  - TCK stays low; `rsp_valid`=1 and `rsp_data`=RX, both held stable until `rsp_ready`.
  - On handshake: back to IDLE.
- `vji_ir_in` holds its last value in IDLE; it changes only on command accept.
- Outside SDR, `vji_tdi`=0. RX is sampled only in SDR.
- Simultaneous `rsp_ready` and `cmd_valid` in RESP: the response completes this cycle. The command is not accepted until the next cycle (IDLE).

## Timing
- Reset values:
  - state IDLE;
  - `cmd_ready`=1, `vji_rti`=1;
  - `vji_tck`=0, `vji_tdi`=0, `vji_ir_in`=0;
  - all strobes 0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- TCK generator:
  - a phase counter counts 0..TCK_DIV-1 and toggles TCK at the terminal count;
  - one TCK period = 2·TCK_DIV clk cycles, low half first;
  - the counter is cleared on entry to UIR.
- Latency: a command accepted at edge N yields UIR starting at cycle N+1. `rsp_valid` rises at edge N+1+(SR_WIDTH+3)·2·TCK_DIV, i.e. N+165 at defaults.
- Throughput: at most one scan in flight. `cmd_ready`=0 from the accept edge until return to IDLE.
- `rsp_valid` is not dropped without `rsp_ready`. `rsp_data` does not change while `rsp_valid`=1.
- Reset asserted mid-scan:
  - all outputs take their reset values asynchronously, with TCK forced low immediately;
  - the partial scan is discarded and no response is produced.
- TCK_DIV=1: TCK toggles every clk; the same ordering holds (strobes and `vji_tdi` update on the TCK-low edge).

## Test plan
- Single scan, defaults, with a behavioural debug-module slave whose SR preloads 38'h2A_5A5A_5A5A on CDR:
  - stimulus `cmd_ir`=2'b01, `cmd_data`=38'h15_A5A5_A5A5;
  - required: `vji_uir` high exactly 4 clk;
  - required: 38 rising TCK edges while `vji_sdr`=1;
  - required: `rsp_data`=38'h2A_5A5A_5A5A at cycle N+165;
  - required: the slave SR holds 38'h15_A5A5_A5A5 at UDR.
- Backpressure: hold `rsp_ready`=0 for 20 cycles after `rsp_valid` → `rsp_valid`/`rsp_data` stable, TCK low, `cmd_ready`=0. Release → IDLE the next cycle.
- Back-to-back commands with `cmd_valid` held high and `rsp_ready` tied 1 → the second accept occurs exactly 1 cycle after the first response handshake; `vji_ir_in` switches 01→10 only at that accept.
- Reset pulse at the 10th SDR rising TCK → TCK=0, `vji_sdr`=0, `vji_ir_in`=0 with no clk edge. No `rsp_valid` follows. The next command completes normally.
- TCK_DIV=1 → TCK period 2 clk, `rsp_valid` at N+83, same `rsp_data` as the first scenario.
- Ordering check over all scans → `vji_tdi` and all strobes never change on a clk edge that drives TCK high.
